// File: rtl/ucode_loader.sv
// Writable 2**AW-entry control store with a byte-stream loader; asynchronous read, one write per edge.
// The core is held (cpu_run=0) from a header until a frame's checksum verifies; in_ready drops only while clearing.
module ucode_loader #(
   parameter int          AW       = 5,
   parameter logic [10:0] DEF_WORD = 11'h7F0
) (
   input  logic          clk,
   input  logic          nReset,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [AW-1:0] rd_addr,
   output logic [3:0]    RegAddr,
   output logic [2:0]    ALUCode,
   output logic          Reg_CE,
   output logic          CY_CE,
   output logic          A_CE,
   output logic          ResetCY,
   output logic          cpu_run,
   output logic          busy,
   output logic          err
);
   localparam int DEPTH = 2 ** AW;
   // Word counter must hold both the largest 6-bit count and DEPTH (count 0 means a full store).
   localparam int RW    = (AW + 1 > 6) ? AW + 1 : 6;

   typedef enum logic [2:0] {S_CLEAR, S_IDLE, S_CNT, S_LO, S_HI, S_CHK} state_t;

   state_t          state, next;
   logic [AW-1:0]   clr_cnt;
   logic [AW-1:0]   ptr;
   logic [RW-1:0]   remaining;
   logic [7:0]      csum;
   logic            bad;
   logic [7:0]      word_lo;
   logic            accept;
   logic            we;
   logic [AW-1:0]   waddr;
   logic [10:0]     wdata;
   logic [10:0]     mem [DEPTH];
   logic [10:0]     rd_word;

   assign accept = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (nReset) state <= S_CLEAR;
      else        state <= next;
   end

   always_comb begin
      next     = state;
      in_ready = 1'b1;
      busy     = 1'b1;
      we       = 1'b0;
      waddr    = ptr;
      wdata    = {in_data[2:0], word_lo};
      case (state)
         S_CLEAR: begin
            in_ready = 1'b0;
            we       = 1'b1;
            waddr    = clr_cnt;
            wdata    = DEF_WORD;
            if (clr_cnt == {AW{1'b1}}) next = S_IDLE;
         end
         S_IDLE: begin
            busy = 1'b0;
            if (accept && in_data[7:5] == 3'b101) next = S_CNT;
         end
         S_CNT: if (accept) next = S_LO;
         S_LO:  if (accept) next = S_HI;
         S_HI: begin
            if (accept) begin
               // Reserved high bits poison the word: skip the write, fail the frame at CHK.
               we   = (in_data[7:3] == 5'd0);
               next = (remaining == RW'(1)) ? S_CHK : S_LO;
            end
         end
         S_CHK: if (accept) next = S_IDLE;
         default: next = S_CLEAR;
      endcase
   end

   always_ff @(posedge clk) begin
      if (nReset) begin
         clr_cnt   <= '0;
         ptr       <= '0;
         remaining <= '0;
         csum      <= '0;
         bad       <= 1'b0;
         word_lo   <= '0;
         cpu_run   <= 1'b0;
         err       <= 1'b0;
      end else begin
         if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
         if (accept) begin
            case (state)
               S_IDLE: begin
                  if (in_data[7:5] == 3'b101) begin
                     ptr     <= in_data[AW-1:0];
                     err     <= 1'b0;
                     cpu_run <= 1'b0;
                  end
               end
               S_CNT: begin
                  remaining <= (in_data[5:0] == 6'd0) ? RW'(DEPTH) : RW'(in_data[5:0]);
                  csum      <= '0;
                  bad       <= 1'b0;
               end
               S_LO: begin
                  word_lo <= in_data;
                  csum    <= csum ^ in_data;
               end
               S_HI: begin
                  csum      <= csum ^ in_data;
                  if (in_data[7:3] != 5'd0) bad <= 1'b1;
                  ptr       <= ptr + 1'b1;
                  remaining <= remaining - 1'b1;
               end
               S_CHK: begin
                  if (in_data == csum && !bad) cpu_run <= 1'b1;
                  else                         err     <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we && !nReset) mem[waddr] <= wdata;
   end

   // Store contents are undefined until CLEAR completes, so the read side is pinned to NOP meanwhile.
   assign rd_word = (state == S_CLEAR) ? DEF_WORD : mem[rd_addr];

   assign RegAddr = rd_word[10:7];
   assign ALUCode = rd_word[6:4];
   assign Reg_CE  = rd_word[3];
   assign CY_CE   = rd_word[2];
   assign A_CE    = rd_word[1];
   assign ResetCY = rd_word[0];

endmodule

// File: tb/tb_ucode_loader.sv
// Directed bench for ucode_loader: expected store contents queued as frames are sent, checked on readback.
module tb_ucode_loader;
   logic        clk = 1'b0;
   logic        nReset;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [4:0]  rd_addr;
   logic [3:0]  RegAddr;
   logic [2:0]  ALUCode;
   logic        Reg_CE, CY_CE, A_CE, ResetCY;
   logic        cpu_run, busy, err;
   logic [10:0] word;

   int total = 0;
   int bad   = 0;
   int max_gap = 0;
   logic [10:0] pre_word;

   typedef struct {
      logic [4:0]  addr;
      logic [10:0] word;
   } exp_t;
   exp_t sb[$];
   logic [7:0] fr[$];

   ucode_loader dut (
      .clk      (clk),
      .nReset   (nReset),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .rd_addr  (rd_addr),
      .RegAddr  (RegAddr),
      .ALUCode  (ALUCode),
      .Reg_CE   (Reg_CE),
      .CY_CE    (CY_CE),
      .A_CE     (A_CE),
      .ResetCY  (ResetCY),
      .cpu_run  (cpu_run),
      .busy     (busy),
      .err      (err)
   );

   assign word = {RegAddr, ALUCode, Reg_CE, CY_CE, A_CE, ResetCY};

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [4:0] a, input logic [10:0] w);
      exp_t e;
      e.addr = a;
      e.word = w;
      sb.push_back(e);
   endtask

   task automatic check_reads(input string tag);
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(negedge clk);
         rd_addr = e.addr;
         #1;
         chk(tag, {21'd0, word}, {21'd0, e.word});
      end
   endtask

   // Drives one byte, optionally after idle gap cycles; returns 1 time unit after the accepting edge.
   task automatic send_byte(input logic [7:0] b);
      int g;
      int n;
      g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
      @(negedge clk);
      repeat (g) @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      #1 pre_word = word;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic send_frame(input logic [7:0] f[$]);
      foreach (f[i]) send_byte(f[i]);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk(tag, {31'd0, busy}, 32'd0);
   endtask

   task automatic push_all_default();
      for (int a = 0; a < 32; a++) push_exp(5'(a), 11'h7F0);
   endtask

   initial begin
      nReset   = 1'b1;
      in_valid = 1'b0;
      in_data  = 8'h00;
      rd_addr  = 5'd0;

      // T1: one reset cycle, then 32 clearing cycles with read outputs pinned to NOP
      @(negedge clk);
      nReset = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rd_addr = 5'(i);
         #1;
         chk("t1_ready_low", {31'd0, in_ready}, 32'd0);
         chk("t1_busy", {31'd0, busy}, 32'd1);
         chk("t1_cpu_run", {31'd0, cpu_run}, 32'd0);
         chk("t1_err", {31'd0, err}, 32'd0);
         chk("t1_forced_word", {21'd0, word}, 32'h7F0);
         @(negedge clk);
      end
      chk("t1_ready_after_clear", {31'd0, in_ready}, 32'd1);
      chk("t1_idle", {31'd0, busy}, 32'd0);
      push_all_default();
      check_reads("t1_store_default");

      // T2: two-word frame at entry 0 with a good checksum
      send_byte(8'hA0);
      chk("t2_busy_in_frame", {31'd0, busy}, 32'd1);
      send_byte(8'h02);
      send_byte(8'h01);
      send_byte(8'h00);
      push_exp(5'd0, 11'h001);
      rd_addr = 5'd1;
      send_byte(8'h16);
      send_byte(8'h04);
      chk("t2_same_cycle_old", {21'd0, pre_word}, 32'h7F0);
      chk("t2_write_visible", {21'd0, word}, 32'h416);
      push_exp(5'd1, 11'h416);
      push_exp(5'd2, 11'h7F0);
      chk("t2_run_before_chk", {31'd0, cpu_run}, 32'd0);
      send_byte(8'h13);
      chk("t2_run_after_chk", {31'd0, cpu_run}, 32'd1);
      chk("t2_err", {31'd0, err}, 32'd0);
      check_reads("t2_store");

      // T3: same frame with a wrong checksum, then the good frame again
      send_byte(8'hA0);
      chk("t3_header_drops_run", {31'd0, cpu_run}, 32'd0);
      fr = '{8'h02, 8'h01, 8'h00, 8'h16, 8'h04, 8'h12};
      send_frame(fr);
      push_exp(5'd0, 11'h001);
      push_exp(5'd1, 11'h416);
      chk("t3_err_set", {31'd0, err}, 32'd1);
      chk("t3_run_low", {31'd0, cpu_run}, 32'd0);
      check_reads("t3_store_kept");
      fr = '{8'hA0, 8'h02, 8'h01, 8'h00, 8'h16, 8'h04, 8'h13};
      send_frame(fr);
      chk("t3_err_cleared", {31'd0, err}, 32'd0);
      chk("t3_run_restored", {31'd0, cpu_run}, 32'd1);

      // T4: start at entry 31 and wrap to entry 0
      fr = '{8'hBF, 8'h02, 8'hAA, 8'h00, 8'h55, 8'h01, 8'hFE};
      send_frame(fr);
      push_exp(5'd31, 11'h0AA);
      push_exp(5'd0, 11'h155);
      push_exp(5'd1, 11'h416);
      chk("t4_run", {31'd0, cpu_run}, 32'd1);
      chk("t4_err", {31'd0, err}, 32'd0);
      check_reads("t4_store_wrap");

      // T5: reserved bit in high byte; checksum matches but the frame still fails
      fr = '{8'hA3, 8'h01, 8'h16, 8'h0C, 8'h1A};
      send_frame(fr);
      push_exp(5'd3, 11'h7F0);
      chk("t5_err", {31'd0, err}, 32'd1);
      chk("t5_run", {31'd0, cpu_run}, 32'd0);
      check_reads("t5_entry_untouched");
      send_byte(8'h00);
      chk("t5_drop_00", {31'd0, busy}, 32'd0);
      send_byte(8'hFF);
      chk("t5_drop_ff", {31'd0, busy}, 32'd0);
      chk("t5_err_held", {31'd0, err}, 32'd1);

      // T6: reset mid-frame re-runs CLEAR; reload with random input gaps
      fr = '{8'hA0, 8'h02, 8'h01};
      send_frame(fr);
      @(negedge clk);
      nReset = 1'b1;
      @(negedge clk);
      nReset = 1'b0;
      #1;
      chk("t6_clear_busy", {31'd0, busy}, 32'd1);
      chk("t6_clear_ready", {31'd0, in_ready}, 32'd0);
      chk("t6_err_reset", {31'd0, err}, 32'd0);
      wait_idle("t6_clear_done");
      chk("t6_run_low", {31'd0, cpu_run}, 32'd0);
      push_all_default();
      check_reads("t6_store_default");
      max_gap = 3;
      fr = '{8'hA0, 8'h02, 8'h01, 8'h00, 8'h16, 8'h04, 8'h13};
      send_frame(fr);
      max_gap = 0;
      push_exp(5'd0, 11'h001);
      push_exp(5'd1, 11'h416);
      push_exp(5'd2, 11'h7F0);
      chk("t6_run", {31'd0, cpu_run}, 32'd1);
      chk("t6_err", {31'd0, err}, 32'd0);
      check_reads("t6_store_gapped");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end
endmodule
